mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Moore finite-state controller for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback steps.
- Drives the 3-bit ALUcontrol code consumed by the ALU, plus every datapath mux select and write strobe.
- Sits between the instruction register (opcode/funct) and the datapath. It is the producer side of the ALU control interface.

Parameters:
- NONE_FETCH_ON_ILLEGAL, 1, when 1 an unrecognised opcode or funct returns to FETCH with no writes; when 0 it halts in the ILLEGAL state until reset.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instr[31:26] from the instruction register; stable from DECODE onward
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag (a == b)
- ir_write  output  1  instruction register load
- pc_en  output  1  PC load = pc_write | (branch & zero)
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  data memory write strobe
- reg_write  output  1  register file write strobe
- reg_dst  output  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = memory data
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2
- pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_control  output  3  ALU op: 000 OR, 001 AND, 010 ADD, 110 SUB, 111 SLT
- state  output  4  current state, for debug and verification
- illegal  output  1  high while in the ILLEGAL state

Behaviour:
- Reset and state register:
  - rst_n low forces state = FETCH asynchronously.
  - While rst_n is low, ir_write, pc_en, mem_write and reg_write are forced to 0 combinationally.
  - All other outputs take their FETCH values during reset: iord 0, alu_src_a 0, alu_src_b 01, alu_control 010, pc_src 00, reg_dst 0, mem_to_reg 0, illegal 0.
- Output style: outputs are a pure function of state, plus funct in EXECUTE and zero in BRANCH. The next state is registered on the rising edge of clk.
- Signals not listed for a state default to 0; alu_control defaults to 010.
- State encodings and behaviour:
  - FETCH (0): iord 0, ir_write 1, alu_src_a 0, alu_src_b 01, ADD, pc_src 00, pc_write 1. Next state DECODE.
  - DECODE (1): alu_src_a 0, alu_src_b 11, ADD (branch target into ALUOut). Next state by opcode:
    - 100011 lw → MEMADR
    - 101011 sw → MEMADR
    - 000000 R-type → EXECUTE
    - 000100 beq → BRANCH
    - 001000 addi → ADDIEXEC
    - 000010 j → JUMP
    - other → ILLEGAL
  - MEMADR (2): alu_src_a 1, alu_src_b 10, ADD. Next state MEMRD for lw, MEMWR for sw.
  - MEMRD (3): iord 1. Next state MEMWB.
  - MEMWB (4): reg_dst 0, mem_to_reg 1, reg_write 1. Next state FETCH.
  - MEMWR (5): iord 1, mem_write 1. Next state FETCH.
  - EXECUTE (6): alu_src_a 1, alu_src_b 00, alu_control decoded from funct:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 001
    - 100101 → 000
    - 101010 → 111
    - Next state ALUWB for a legal funct, otherwise ILLEGAL.
  - ALUWB (7): reg_dst 1, mem_to_reg 0, reg_write 1. Next state FETCH.
  - BRANCH (8): alu_src_a 1, alu_src_b 00, SUB, pc_src 01, branch 1, so pc_en = zero. Next state FETCH.
  - ADDIEXEC (9): alu_src_a 1, alu_src_b 10, ADD. Next state ADDIWB.
  - ADDIWB (10): reg_dst 0, mem_to_reg 0, reg_write 1. Next state FETCH.
  - JUMP (11): pc_src 10, pc_write 1. Next state FETCH.
  - ILLEGAL (12): no strobes, illegal 1.
    - NONE_FETCH_ON_ILLEGAL = 1: next state FETCH.
    - NONE_FETCH_ON_ILLEGAL = 0: stay in ILLEGAL.
  - Encodings 13–15: treated as ILLEGAL; next state FETCH regardless of parameter.
- Cycle counts (FETCH to FETCH):
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal: 3
- Boundary conditions:
  - At most one of mem_write and reg_write is high in any cycle. ir_write is high only in FETCH.
  - opcode/funct changes outside DECODE/EXECUTE/MEMADR have no effect on the state sequence.
  - rst_n asserted mid-instruction (for example in MEMWR) cancels the strobe in that same cycle. Execution restarts at FETCH on the first clk edge after rst_n rises.

Test Plan:
- Reset released, opcode 100011 held: state sequence 0,1,2,3,4,0. mem_to_reg = 1 and reg_write = 1 only in state 4. ir_write = 1 only in state 0.
- R-type, funct 101010: states 0,1,6,7. alu_control = 111 in state 6. reg_dst = 1 and reg_write = 1 in state 7.
- beq with zero = 1, then with zero = 0: in state 8, alu_control = 110 and pc_src = 01 both times; pc_en is 1 for the first case and 0 for the second.
- sw with rst_n pulled low during state 5: mem_write drops to 0 immediately and state = 0. After release, the next cycle shows FETCH outputs with ir_write = 1.
- opcode 111111: states 0,1,12,0 with illegal = 1 for one cycle and no strobes. Repeat with NONE_FETCH_ON_ILLEGAL = 0: state stays 12.
- j (000010): states 0,1,11,0 with pc_src = 10 and pc_en = 1 in state 11. addi: states 0,1,9,10 with alu_src_b = 10 in state 9.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: instruction fields in, datapath selects and strobes out
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ir_write;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, funct, zero,
        output ir_write, pc_en, iord, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, alu_control, state, illegal
    );

    modport slave (
        output opcode, funct, zero,
        input  ir_write, pc_en, iord, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, alu_control, state, illegal
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing the multicycle MIPS datapath
module mips_multicycle_control #(
    parameter bit NONE_FETCH_ON_ILLEGAL = 1'b1
) (
    input logic clk,
    input logic rst_n,
    mips_multicycle_control_if.master bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMRD    = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWR    = 4'd5;
    localparam logic [3:0] EXECUTE  = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] ADDIEXEC = 4'd9;
    localparam logic [3:0] ADDIWB   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;
    localparam logic [3:0] ILLEGAL  = 4'd12;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0] state_q, state_d;
    logic [2:0] funct_alu;
    logic       funct_ok;
    logic       ir_write_s, pc_write, branch, mem_write_s, reg_write_s;
    logic       iord, reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    // state register; reset lands in FETCH without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // R-type funct to ALU op; unknown funct falls back to ADD and is flagged
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (bus.funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b001;
            6'b100101: funct_alu = 3'b000;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // next-state selection; opcode only matters in DECODE and MEMADR
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE:   state_d = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                                (bus.opcode == OP_R)    ? EXECUTE  :
                                (bus.opcode == OP_BEQ)  ? BRANCH   :
                                (bus.opcode == OP_ADDI) ? ADDIEXEC :
                                (bus.opcode == OP_J)    ? JUMP     : ILLEGAL;
            MEMADR:   state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            EXECUTE:  state_d = funct_ok ? ALUWB : ILLEGAL;
            ADDIEXEC: state_d = ADDIWB;
            ILLEGAL:  state_d = NONE_FETCH_ON_ILLEGAL ? FETCH : ILLEGAL;
            default:  state_d = FETCH;
        endcase
    end

    // Moore decode of datapath controls; unlisted signals stay at their defaults
    always_comb begin
        ir_write_s  = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_control = 3'b010;
        illegal     = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write_s = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b01;
            end
            DECODE:   alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD:    iord = 1'b1;
            MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
            end
            MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
            end
            EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                branch      = 1'b1;
            end
            ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB:   reg_write_s = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default:  illegal = 1'b1;
        endcase
    end

    // strobes are gated by rst_n so a reset cancels them in the same cycle
    assign bus.ir_write    = ir_write_s & rst_n;
    assign bus.pc_en       = (pc_write | (branch & bus.zero)) & rst_n;
    assign bus.mem_write   = mem_write_s & rst_n;
    assign bus.reg_write   = reg_write_s & rst_n;
    assign bus.iord        = iord;
    assign bus.reg_dst     = reg_dst;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.pc_src      = pc_src;
    assign bus.alu_control = alu_control;
    assign bus.state       = state_q;
    assign bus.illegal     = illegal;
endmodule
